// File: rtl/unibus_master.sv
// ARM-commanded UNIBUS initiator: one DATI, DATO or DATOB per go command, with NPR
// arbitration, address deskew, MSYN/SSYN handshake, timeout and INIT abort.
module unibus_master (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [1:0]  armraddr,
    input  logic [1:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h,
    output logic        msyn_out_h,
    output logic        bbsy_out_h,
    output logic        npr_out_h,
    output logic        sack_out_h,
    input  logic [15:0] d_in_h,
    input  logic        ssyn_in_h,
    input  logic        npg_in_h,
    input  logic        bbsy_in_h,
    input  logic        init_in_h
);
    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_GRANT, S_WAITBUS, S_DESKEW,
        S_MSYN, S_LATCH, S_NEGMSYN, S_WAITSSYN0, S_HOLD
    } state_t;

    localparam logic [9:0] TMO_LAST    = 10'd999;
    localparam logic [9:0] DESKEW_LAST = 10'd14;
    localparam logic [9:0] LATCH_LAST  = 10'd7;
    localparam logic [9:0] HOLD_LAST   = 10'd9;

    state_t      state_q;
    logic [9:0]  cnt_q;
    logic [17:0] addr_q;
    logic [1:0]  ctl_q;
    logic [15:0] data_q;
    logic        tmo_q;
    logic        abort_q;
    logic [17:0] a_q;
    logic [1:0]  c_q;
    logic [15:0] d_q;
    logic        msyn_q;
    logic        bbsy_q;
    logic        npr_q;
    logic        sack_q;

    logic go_d;
    logic busy_d;
    logic tmo_hit_d;
    logic bus_free_d;
    logic unused_wdata;

    assign go_d         = armwrite && (armwaddr == 2'd1) && armwdata[31] && !init_in_h;
    assign busy_d       = (state_q != S_IDLE);
    assign tmo_hit_d    = (cnt_q == TMO_LAST);
    assign bus_free_d   = !npg_in_h && !bbsy_in_h && !ssyn_in_h;
    assign unused_wdata = ^armwdata[30:20];

    assign a_out_h    = a_q;
    assign c_out_h    = c_q;
    assign d_out_h    = d_q;
    assign msyn_out_h = msyn_q;
    assign bbsy_out_h = bbsy_q;
    assign npr_out_h  = npr_q;
    assign sack_out_h = sack_q;

    always_comb begin
        armrdata = '0;
        case (armraddr)
            2'd0:    armrdata = 32'h554D1001;
            2'd1:    armrdata = {busy_d, tmo_q, abort_q, 9'd0, ctl_q, addr_q};
            2'd2:    armrdata = {16'd0, data_q};
            default: armrdata = '0;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ctl_q   <= '0;
            data_q  <= '0;
            tmo_q   <= 1'b0;
            abort_q <= 1'b0;
            a_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            msyn_q  <= 1'b0;
            bbsy_q  <= 1'b0;
            npr_q   <= 1'b0;
            sack_q  <= 1'b0;
        end else if (init_in_h && busy_d) begin
            // Bus INIT aborts whatever is in flight; the data register is left alone.
            state_q <= S_IDLE;
            cnt_q   <= '0;
            abort_q <= 1'b1;
            a_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            msyn_q  <= 1'b0;
            bbsy_q  <= 1'b0;
            npr_q   <= 1'b0;
            sack_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (armwrite && (armwaddr == 2'd2)) begin
                        data_q <= armwdata[15:0];
                    end
                    if (go_d) begin
                        addr_q  <= armwdata[17:0];
                        ctl_q   <= armwdata[19:18];
                        tmo_q   <= 1'b0;
                        abort_q <= 1'b0;
                        npr_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (npg_in_h) begin
                        npr_q   <= 1'b0;
                        sack_q  <= 1'b1;
                        cnt_q   <= cnt_q + 10'd1;
                        state_q <= S_GRANT;
                    end else if (tmo_hit_d) begin
                        tmo_q   <= 1'b1;
                        npr_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                S_GRANT: begin
                    if (tmo_hit_d) begin
                        tmo_q   <= 1'b1;
                        sack_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 10'd1;
                        state_q <= S_WAITBUS;
                    end
                end
                S_WAITBUS: begin
                    if (bus_free_d) begin
                        bbsy_q  <= 1'b1;
                        sack_q  <= 1'b0;
                        a_q     <= addr_q;
                        c_q     <= ctl_q;
                        d_q     <= ctl_q[1] ? data_q : 16'd0;
                        cnt_q   <= '0;
                        state_q <= S_DESKEW;
                    end else if (tmo_hit_d) begin
                        tmo_q   <= 1'b1;
                        sack_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                S_DESKEW: begin
                    if (cnt_q == DESKEW_LAST) begin
                        msyn_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_MSYN;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                S_MSYN: begin
                    if (ssyn_in_h) begin
                        cnt_q   <= '0;
                        state_q <= ctl_q[1] ? S_NEGMSYN : S_LATCH;
                    end else if (tmo_hit_d) begin
                        tmo_q   <= 1'b1;
                        msyn_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                S_LATCH: begin
                    // Slave data is given eight cycles past SSYN to settle before capture.
                    if (cnt_q == LATCH_LAST) begin
                        data_q  <= d_in_h;
                        cnt_q   <= '0;
                        state_q <= S_NEGMSYN;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                S_NEGMSYN: begin
                    msyn_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_WAITSSYN0;
                end
                S_WAITSSYN0: begin
                    if (!ssyn_in_h || tmo_hit_d) begin
                        tmo_q   <= tmo_q | ssyn_in_h;
                        cnt_q   <= '0;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        a_q     <= '0;
                        c_q     <= '0;
                        d_q     <= '0;
                        msyn_q  <= 1'b0;
                        bbsy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_unibus_master.sv
// Bench for unibus_master: open-loop responder tables, a timeline model of the bus
// outputs derived from event times, and literal checks on key latencies.
module tb_unibus_master;
    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        armwrite = 1'b0;
    logic [1:0]  armraddr = 2'd0;
    logic [1:0]  armwaddr = 2'd0;
    logic [31:0] armwdata = 32'd0;
    logic [31:0] armrdata;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h;
    logic        msyn_out_h, bbsy_out_h, npr_out_h, sack_out_h;
    logic [15:0] d_in_h = 16'd0;
    logic        ssyn_in_h = 1'b0, npg_in_h = 1'b0, bbsy_in_h = 1'b0, init_in_h = 1'b0;

    int vec = 0;
    int miss = 0;

    unibus_master dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
        .armwdata(armwdata), .armrdata(armrdata),
        .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h),
        .msyn_out_h(msyn_out_h), .bbsy_out_h(bbsy_out_h),
        .npr_out_h(npr_out_h), .sack_out_h(sack_out_h),
        .d_in_h(d_in_h), .ssyn_in_h(ssyn_in_h), .npg_in_h(npg_in_h),
        .bbsy_in_h(bbsy_in_h), .init_in_h(init_in_h)
    );

    always #5 CLOCK = ~CLOCK;

    // Scenario description: edge 0 is the clock edge that samples the go write.
    logic [17:0] sc_addr;
    logic [1:0]  sc_ctl;
    logic [15:0] sc_wdata, sc_dval;
    bit          sc_grant, sc_busy_wr;
    int          sc_S, sc_F, sc_I;
    // Event times derived from the bus protocol rules.
    int t_B, t_M, t_msyn_end, t_T, t_R;
    int k_now = 0;
    bit model_on = 1'b0;
    int ev_msyn_rise, ev_bbsy_rise, ev_tmo_rise, ev_busy_clr, ev_npr_fall;
    bit ev_bbsy_seen;
    logic prev_msyn, prev_bbsy, prev_tmo, prev_busy, prev_npr;
    logic [39:0] cmp_eb, cmp_ab;
    logic [31:0] cmp_es;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vec++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    function automatic void compute_times();
        int hold_start, lat;
        t_T = -1;
        if (!sc_grant) begin
            t_B = -1; t_M = -1; t_msyn_end = -2;
            t_T = 1000; t_R = 1000;
        end else begin
            t_B = 3;            // REQ, GRANT, WAITBUS one cycle each
            t_M = t_B + 15;     // deskew
            if (sc_S < 0) begin
                t_T = t_M + 1000;
                t_msyn_end = t_T - 1;
                hold_start = t_T;
            end else begin
                lat = sc_ctl[1] ? 0 : 8;
                t_msyn_end = sc_S + lat;
                hold_start = (sc_F > t_msyn_end + 2) ? sc_F : t_msyn_end + 2;
            end
            t_R = hold_start + 10;
        end
        if (sc_I >= 0 && sc_I < t_R) t_R = sc_I;
    endfunction

    function automatic logic [39:0] exp_bus(input int k);
        bit ab, own, npr, sack, msyn;
        ab   = (sc_I >= 0) && (k >= sc_I);
        npr  = !ab && (sc_grant ? (k == 0) : (k < 1000));
        sack = !ab && sc_grant && (k == 1 || k == 2);
        own  = !ab && sc_grant && (k >= t_B) && (k < t_R);
        msyn = !ab && sc_grant && (k >= t_M) && (k <= t_msyn_end);
        return {npr, sack, own, msyn, own ? sc_ctl : 2'b00, own ? sc_addr : 18'd0,
                (own && sc_ctl[1]) ? sc_wdata : 16'd0};
    endfunction

    function automatic logic [31:0] exp_status(input int k);
        bit busy, tmo, ab;
        ab   = (sc_I >= 0) && (k >= sc_I);
        busy = (k < t_R);
        tmo  = (t_T >= 0) && (k >= t_T);
        return {busy, tmo, ab, 9'd0, sc_ctl, sc_addr};
    endfunction

    task automatic quiet();
        armwrite = 1'b0; npg_in_h = 1'b0; ssyn_in_h = 1'b0;
        init_in_h = 1'b0; bbsy_in_h = 1'b0; d_in_h = 16'd0;
    endtask

    // Inputs sampled at edge j.
    task automatic drive(input int j);
        npg_in_h  = sc_grant && (j == 1 || j == 2);
        ssyn_in_h = (sc_S >= 0) && (j >= sc_S) && (j < sc_F);
        d_in_h    = (sc_S >= 0 && j == sc_S + 8) ? sc_dval : (16'h0F0F ^ 16'(j));
        init_in_h = (j == sc_I);
        bbsy_in_h = 1'b0;
        armwrite  = sc_busy_wr && (j == 5 || j == 6);
        armwaddr  = (j == 6) ? 2'd2 : 2'd1;
        armwdata  = (j == 5) ? {1'b1, 11'd0, 2'b10, 18'o000100} : 32'h00000BAD;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge CLOCK); #1;
        armwrite = 1'b1; armwaddr = a; armwdata = d;
        @(posedge CLOCK); #1;
        armwrite = 1'b0;
    endtask

    task automatic run_txn(input string name, input logic [17:0] addr, input logic [1:0] ctl,
                           input bit grant, input int s, input int f, input int i,
                           input bit bw, input logic [15:0] dval, input logic [15:0] wdata,
                           input int stop_k);
        int last;
        sc_addr = addr; sc_ctl = ctl; sc_grant = grant; sc_S = s; sc_F = f; sc_I = i;
        sc_busy_wr = bw; sc_dval = dval; sc_wdata = wdata;
        compute_times();
        last = (stop_k >= 0) ? stop_k : t_R + 2;
        ev_msyn_rise = -1; ev_bbsy_rise = -1; ev_tmo_rise = -1; ev_busy_clr = -1; ev_npr_fall = -1;
        ev_bbsy_seen = 1'b0;
        prev_msyn = 1'b0; prev_bbsy = 1'b0; prev_tmo = 1'b0; prev_busy = 1'b0; prev_npr = 1'b0;
        armraddr = 2'd1;
        @(posedge CLOCK); #1;
        quiet();
        armwrite = 1'b1; armwaddr = 2'd1; armwdata = {1'b1, 11'd0, ctl, addr};
        @(posedge CLOCK);
        k_now = 0; model_on = 1'b1;
        #1 drive(1);
        while (k_now < last) begin
            @(posedge CLOCK);
            k_now++;
            #1 drive(k_now + 1);
        end
        @(negedge CLOCK); #1;
        model_on = 1'b0;
        quiet();
        $display("txn %s addr=%o ctl=%b: edges 0..%0d compared against model", name, addr, ctl, last);
    endtask

    // Single compare process: model versus DUT on every cycle of a transaction.
    always @(negedge CLOCK) begin
        if (model_on) begin
            cmp_eb = exp_bus(k_now);
            cmp_ab = {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, c_out_h, a_out_h, d_out_h};
            cmp_es = exp_status(k_now);
            vec += 2;
            if (cmp_ab !== cmp_eb) begin
                miss++;
                $display("FAIL bus k=%0d: got %h, required %h", k_now, cmp_ab, cmp_eb);
            end
            if (armrdata !== cmp_es) begin
                miss++;
                $display("FAIL status k=%0d: got %h, required %h", k_now, armrdata, cmp_es);
            end
            if (msyn_out_h && !prev_msyn && ev_msyn_rise < 0) ev_msyn_rise = k_now;
            if (bbsy_out_h && !prev_bbsy && ev_bbsy_rise < 0) ev_bbsy_rise = k_now;
            if (armrdata[30] && !prev_tmo && ev_tmo_rise < 0) ev_tmo_rise = k_now;
            if (!armrdata[31] && prev_busy && ev_busy_clr < 0) ev_busy_clr = k_now;
            if (!npr_out_h && prev_npr && ev_npr_fall < 0) ev_npr_fall = k_now;
            if (bbsy_out_h) ev_bbsy_seen = 1'b1;
            prev_msyn = msyn_out_h; prev_bbsy = bbsy_out_h; prev_tmo = armrdata[30];
            prev_busy = armrdata[31]; prev_npr = npr_out_h;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        #23;
        chk("reset_bus", {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, c_out_h, a_out_h, d_out_h}, 64'd0);
        armraddr = 2'd0; #1;
        chk("id_reg", armrdata, 64'h554D1001);
        armraddr = 2'd1; #1;
        chk("status_reset", armrdata, 64'd0);
        armraddr = 2'd3; #1;
        chk("reg3_zero", armrdata, 64'd0);
        @(negedge CLOCK); RESET = 1'b1;

        // DATO 123456 -> 777546, SSYN 5 cycles after MSYN, go/data writes while busy.
        wr(2'd2, 32'h0000A72E);
        run_txn("DATO", 18'o777546, 2'b10, 1'b1, 23, 27, -1, 1'b1, 16'h0000, 16'hA72E, -1);
        chk("dato_deskew", 64'(ev_msyn_rise - ev_bbsy_rise), 64'd15);
        chk("dato_busy_clr", 64'(ev_busy_clr), 64'd37);
        armraddr = 2'd1; #1;
        chk("dato_status", armrdata, {32'd0, 3'b000, 9'd0, 2'b10, 18'o777546});
        armraddr = 2'd2; #1;
        chk("dato_reg2_kept", armrdata, 64'h0000A72E);

        // Minimum DATOB: immediate SSYN for one cycle.
        wr(2'd2, 32'h000000C3);
        run_txn("DATOB", 18'o000777, 2'b11, 1'b1, 19, 20, -1, 1'b0, 16'h0000, 16'h00C3, -1);
        chk("datob_busy_clr", 64'(ev_busy_clr), 64'd31);

        // DATI from 001000, slave returns 177777.
        run_txn("DATI", 18'o001000, 2'b00, 1'b1, 21, 32, -1, 1'b0, 16'hFFFF, 16'h0000, -1);
        armraddr = 2'd2; #1;
        chk("dati_reg2", armrdata, 64'h0000FFFF);
        chk("dati_busy_clr", 64'(ev_busy_clr), 64'd42);

        // DATI with no responder.
        run_txn("DATI_NORESP", 18'o760000, 2'b00, 1'b1, -1, 0, -1, 1'b0, 16'h0000, 16'h0000, -1);
        chk("noresp_tmo_delay", 64'(ev_tmo_rise - ev_msyn_rise), 64'd1000);
        chk("noresp_busy_clr", 64'(ev_busy_clr), 64'd1028);

        // Grant never arrives.
        run_txn("NOGRANT", 18'o777700, 2'b10, 1'b0, -1, 0, -1, 1'b0, 16'h0000, 16'hFFFF, -1);
        chk("nogrant_npr_drop", 64'(ev_npr_fall), 64'd1000);
        chk("nogrant_no_bbsy", 64'(ev_bbsy_seen), 64'd0);
        armraddr = 2'd1; #1;
        chk("nogrant_status", armrdata[31:29], 64'b010);

        // INIT while idle has no effect; go with INIT in the same cycle is dropped.
        @(posedge CLOCK); #1 init_in_h = 1'b1;
        @(posedge CLOCK); #1 init_in_h = 1'b0;
        chk("idle_init", armrdata[31:29], 64'b010);
        @(posedge CLOCK); #1;
        armwrite = 1'b1; armwaddr = 2'd1; armwdata = {1'b1, 11'd0, 2'b10, 18'o000002}; init_in_h = 1'b1;
        @(posedge CLOCK); #1;
        armwrite = 1'b0; init_in_h = 1'b0;
        chk("go_init_npr", 64'(npr_out_h), 64'd0);
        chk("go_init_status", armrdata, {32'd0, 3'b010, 9'd0, 2'b10, 18'o777700});

        // INIT during deskew.
        wr(2'd2, 32'h00001357);
        run_txn("INIT_DESKEW", 18'o172340, 2'b00, 1'b1, -1, 0, 10, 1'b0, 16'h0000, 16'h0000, -1);
        chk("init_busy_clr", 64'(ev_busy_clr), 64'd10);
        armraddr = 2'd1; #1;
        chk("init_status", armrdata[31:29], 64'b001);
        armraddr = 2'd2; #1;
        chk("init_reg2_kept", armrdata, 64'h00001357);

        // Asynchronous reset in the middle of MSYN.
        run_txn("RESET_MSYN", 18'o777560, 2'b10, 1'b1, -1, 0, -1, 1'b0, 16'h0000, 16'h1357, 21);
        chk("pre_reset_msyn", 64'(msyn_out_h), 64'd1);
        RESET = 1'b0; #1;
        chk("reset_msyn", 64'(msyn_out_h), 64'd0);
        chk("reset_bus_mid", {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, c_out_h, a_out_h, d_out_h}, 64'd0);
        armraddr = 2'd1; #1;
        chk("reset_status_mid", armrdata, 64'd0);
        armraddr = 2'd2; #1;
        chk("reset_reg2_mid", armrdata, 64'd0);
        @(negedge CLOCK); RESET = 1'b1;
        repeat (3) @(posedge CLOCK);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/unibus_master.md
# unibus_master

ARM-driven UNIBUS bus master. It performs single DATI, DATO or DATOB cycles on the PDP-11 bus on behalf of the ARM processor: NPR arbitration, address/control deskew, the MSYN/SSYN handshake, data capture, and bus release. It is the initiator counterpart of the slave register devices (line clock, terminals) that answer MSYN with SSYN. It sits beside those devices on the shared ARM register bus and UNIBUS pin multiplexing.

## Interface
- Parameters: none. CLOCK is fixed at 100 MHz, and all delays below are stated in CLOCK cycles.
- CLOCK  in  1  system clock, 100 MHz
- RESET  in  1  asynchronous, active-low reset
- armwrite  in  1  ARM write strobe, one cycle
- armraddr, armwaddr  in  2 each  ARM read/write register select
- armwdata  in  32  ARM write data
- armrdata  out  32  ARM read data, combinational
- a_out_h  out  18  bus address
- c_out_h  out  2  bus control: 00 = DATI, 10 = DATO, 11 = DATOB
- d_out_h  out  16  bus write data
- msyn_out_h, bbsy_out_h, npr_out_h, sack_out_h  out  1 each  bus control lines
- d_in_h  in  16  bus data
- ssyn_in_h, npg_in_h, bbsy_in_h, init_in_h  in  1 each  bus control lines

## Operation
- Register 0 reads 32'h554D1001 ('UM', 4 registers, version 1).
- Register 1 is command/status: [31] busy/go, [30] timeout error, [29] init-abort, [19:18] control code, [17:00] address.
- Register 2 is data: [15:00] holds write data, or read data after a DATI; [31:16] read as 0.
- Register 3 reads 0.
- Writing register 1 with [31]=1 while idle latches the address and control code, clears [30:29], and sets busy.
- Writes to register 1 or register 2 while busy are ignored.
- States: IDLE, REQ, GRANT, WAITBUS, DESKEW, MSYN, LATCH, NEGMSYN, WAITSSYN0, HOLD.
- REQ: assert npr_out_h.
- GRANT, entered when npg_in_h=1: assert sack_out_h and drop npr_out_h.
- WAITBUS: wait until npg_in_h, bbsy_in_h and ssyn_in_h are all 0. Then assert bbsy_out_h, drop sack_out_h, and drive a_out_h and c_out_h. For DATO/DATOB, also drive d_out_h from register 2.
- DESKEW: hold 15 cycles, then assert msyn_out_h.
- MSYN: wait for ssyn_in_h=1.
  - For DATI, go to LATCH: wait 8 cycles, then copy d_in_h into register 2.
  - For DATO/DATOB, go directly to NEGMSYN.
- NEGMSYN: drop msyn_out_h.
- WAITSSYN0: wait for ssyn_in_h=0.
- HOLD: keep address, control and data stable 10 cycles. Then drive all bus outputs to 0, drop bbsy_out_h, clear busy, and return to IDLE.
- Timeout: a 10-bit counter is cleared on entry to REQ, MSYN and WAITSSYN0.
  - If it reaches 1000 in REQ/GRANT/WAITBUS, MSYN or WAITSSYN0, set [30] and go to the release path.
  - The release path drops msyn_out_h, runs HOLD, then returns to IDLE.
  - If the timeout occurs before bbsy_out_h was asserted, release immediately.
- init_in_h=1 in any non-IDLE state: the next cycle drives every bus output to 0, sets [29], clears busy, and returns to IDLE. Register 2 is unchanged.
- init_in_h=1 while IDLE has no effect.
- A go write and init_in_h=1 in the same cycle: init wins, and the command is not started.
- Bus outputs are 0 whenever the block does not own the bus.

## Timing
- RESET low forces state IDLE and clears every output and every register (including busy, [30] and [29]), asynchronously.
- armrdata reflects register updates on the cycle after the write.
- Minimum DATO with immediate grant and SSYN is: go write +1 REQ, +1 GRANT, +1 WAITBUS, 15 DESKEW, MSYN, NEGMSYN, WAITSSYN0, then 10 HOLD. Busy clears at the end of HOLD.
- DATI adds the 8 LATCH cycles. d_in_h is sampled exactly 8 cycles after ssyn_in_h is first seen high.
- msyn_out_h never rises fewer than 15 cycles after a_out_h becomes valid.
- a_out_h never changes within 10 cycles after ssyn_in_h is seen low.

## Test plan
- DATO: write register 2 = 16'o123456, then register 1 = {1'b1, 2'b10, 18'o777546}. Grant at once; the responder raises SSYN 5 cycles after MSYN. Required: MSYN rises 15 cycles after BBSY, d_out_h = 123456, and busy clears with [30:29] = 0.
- DATI: command {1, 00, 18'o001000}; the responder drives 16'o177777 with SSYN. Required: register 2 reads 0x0000FFFF and busy clears.
- No responder: DATI to 18'o760000 with SSYN never raised. Required: [30] sets 1000 cycles after MSYN rises, MSYN drops, all outputs are 0, and busy clears.
- Grant never arrives (npg_in_h held 0). Required: npr_out_h drops after 1000 cycles, [30] = 1, and bbsy_out_h is never asserted.
- init_in_h pulses during DESKEW. Required: all bus outputs are 0 on the next cycle, [29] = 1, and busy = 0.
- A register 1 go write issued while busy is ignored; the address seen on the bus is the first command's. Asserting RESET low mid-MSYN clears msyn_out_h immediately.
